fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of decode. It owns the program counter and drives the instruction-memory address. It registers the fetched instruction into the fetch/decode pipeline register (instr_p, pc_p, valid_p) that the control unit, immediate generator and register file consume. It handles decode-side stalls, branch/jump redirects with flush, and instruction-memory wait states by inserting bubbles.

Parameters:
XLEN, 32, datapath and PC width.
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in instr_p on flush, wait or reset.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
imem_addr  output  XLEN  instruction-memory byte address; combinational copy of the PC register.
imem_instr  input  32  instruction returned for imem_addr; valid when imem_ready=1.
imem_ready  input  1  instruction memory has valid data this cycle.
stall  input  1  hold request from hazard/load-use logic; freezes PC and the pipeline register.
redirect  input  1  branch taken or jump resolved downstream.
redirect_pc  input  XLEN  redirect target byte address.
instr_p  output  32  registered instruction to decode.
pc_p  output  XLEN  PC of instr_p, for AUIPC/JAL/branch targets.
pc4_p  output  XLEN  pc_p+4, the link value for JAL/JALR.
valid_p  output  1  instr_p is a real instruction (0 = bubble).
misalign_err  output  1  sticky flag; set when a redirect target has [1:0] != 0.
fetch_cnt  output  32  count of valid instructions delivered to decode.

Behaviour:
- Reset (reset=0, asynchronous; takes effect without a clock edge):
  - pc=RESET_PC, instr_p=NOP_INSTR, pc_p=0, pc4_p=0, valid_p=0.
  - misalign_err=0, fetch_cnt=0.
  - Release is synchronous to the next clk edge. The first fetch address is RESET_PC.
- imem_addr=pc at all times. There is no registered address path, so there are zero cycles from PC to address.
- Per-edge update priority is redirect > stall > wait > normal:
  - redirect=1, regardless of stall or imem_ready:
    - pc <= {redirect_pc[XLEN-1:2],2'b00}.
    - instr_p <= NOP_INSTR, valid_p <= 0. The wrong-path instruction is flushed.
    - pc_p and pc4_p are held.
    - If redirect_pc[1:0] != 0, misalign_err <= 1.
  - stall=1, redirect=0: pc, instr_p, pc_p, pc4_p and valid_p all hold. imem_ready is ignored.
  - imem_ready=0, stall=0, redirect=0:
    - pc holds.
    - instr_p <= NOP_INSTR, valid_p <= 0.
    - pc_p and pc4_p hold.
  - Normal (imem_ready=1, no stall, no redirect):
    - instr_p <= imem_instr, pc_p <= pc, pc4_p <= pc+4, valid_p <= 1.
    - pc <= pc+4.
- Latency: an instruction presented at imem_addr=A appears on instr_p with pc_p=A one edge later.
- Arithmetic:
  - pc+4 is modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0.
  - fetch_cnt increments by 1 on each edge where valid_p is loaded with 1, and wraps at 2^32.
- misalign_err stays set until reset. The stage continues operating with the masked target.
- Mid-operation reset clears all state immediately, including a pending stall or redirect. There is no handshake to complete.
- No combinational path from any input to any registered output. The only combinational output is imem_addr, which depends on the pc register only.

Decomposition:
- Shared package riscv_pkg holds XLEN, RESET_PC, NOP_INSTR, and the opcode constants already used by the control unit.
- One sub-module, fetch_pc_reg, holds:
  - the PC register;
  - the redirect/stall/wait next-PC mux;
  - the +4 adder and the alignment mask.
- The fetch_stage top holds the fetch/decode register, the flags and the counter.

Test Plan:
1. Reset release, imem_ready=1, memory returns word=addr^32'hA5A5_0000:
   - After 3 edges: pc_p=0x8, instr_p=0xA5A5_0008, pc4_p=0xC, valid_p=1, fetch_cnt=3.
   - Assert reset mid-run: all outputs return to reset values with no clk edge.
2. At pc=0x10, hold stall=1 for 2 edges:
   - instr_p, pc_p=0xC and imem_addr=0x10 are unchanged; fetch_cnt is unchanged.
   - After release, the next edge gives pc_p=0x10.
3. At pc=0x20, pulse redirect=1 with redirect_pc=0x100 and stall=1 in the same cycle:
   - Next edge: valid_p=0, instr_p=0x0000_0013, imem_addr=0x100.
   - Following edge: pc_p=0x100.
4. Drop imem_ready for 3 cycles at pc=0x40:
   - 3 bubbles (valid_p=0) are delivered and imem_addr stays at 0x40.
   - On recovery, pc_p=0x40 with the correct instruction; no instruction is skipped or duplicated.
5. Redirect to 0x0000_0206:
   - imem_addr=0x204 and misalign_err=1, which persists through later redirects until reset.
   - Separately, redirect to 0xFFFF_FFFC, fetch twice: the second pc_p=0x0, and pc4_p of the first equals 0x0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, reset/bubble encodings,
// base opcodes used by the control unit, and the fetch-stage action decode.
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  // RV32I base opcodes (instr[6:0]).
  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  // What the fetch stage does on the coming clock edge.
  typedef enum logic [1:0] {
    ACT_FETCH,     // accept imem_instr, advance PC
    ACT_WAIT,      // memory not ready: insert a bubble, hold PC
    ACT_STALL,     // decode hold: freeze everything
    ACT_REDIRECT   // branch/jump: flush and load the target
  } fetch_act_e;

  // Priority is redirect > stall > wait > normal.
  function automatic fetch_act_e fetch_action(input logic redirect,
                                              input logic stall,
                                              input logic ready);
    if (redirect)   return ACT_REDIRECT;
    else if (stall) return ACT_STALL;
    else if (!ready) return ACT_WAIT;
    else            return ACT_FETCH;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with its next-PC mux, +4 adder and the
// word-alignment mask applied to redirect targets.
module fetch_pc_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  fetch_act_e      act,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] pc_next;

  // Sequential +4 wraps modulo 2^XLEN by construction.
  assign pc4 = pc + XLEN'(4);

  // Select the next PC from the action decoded for this edge.
  always_comb begin
    // NOTE: default first so every path assigns pc_next and no latch is inferred.
    pc_next = pc;
    case (act)
      ACT_REDIRECT: pc_next = redirect_pc & ALIGN_MASK;
      ACT_FETCH:    pc_next = pc4;
      default:      pc_next = pc;  // stall and wait both hold
    endcase
  end

  // PC state register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments for all sequential state.
    if (!reset) pc <= RESET_PC;
    else        pc <= pc_next;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives imem_addr from the PC and registers the
// fetched word into the fetch/decode pipeline register, inserting bubbles
// on redirect flushes and memory wait states.
module fetch_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_instr,
  input  logic            imem_ready,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     instr_p,
  output logic [XLEN-1:0] pc_p,
  output logic [XLEN-1:0] pc4_p,
  output logic            valid_p,
  output logic            misalign_err,
  output logic [31:0]     fetch_cnt
);

  fetch_act_e      act;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc4;

  assign act       = fetch_action(redirect, stall, imem_ready);
  assign imem_addr = pc;

  fetch_pc_reg u_pc (
    .clk         (clk),
    .reset       (reset),
    .act         (act),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .pc4         (pc4)
  );

  // Fetch/decode register: load on fetch, bubble on redirect/wait, hold on stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_p <= NOP_INSTR;
      pc_p    <= '0;
      pc4_p   <= '0;
      valid_p <= 1'b0;
    end else begin
      case (act)
        ACT_FETCH: begin
          instr_p <= imem_instr;
          pc_p    <= pc;
          pc4_p   <= pc4;
          valid_p <= 1'b1;
        end
        ACT_REDIRECT, ACT_WAIT: begin
          instr_p <= NOP_INSTR;
          valid_p <= 1'b0;
        end
        default: ;  // stall: hold everything
      endcase
    end
  end

  // Sticky misaligned-target flag and delivered-instruction counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_err <= 1'b0;
      fetch_cnt    <= '0;
    end else begin
      if (act == ACT_REDIRECT && redirect_pc[1:0] != 2'b00)
        misalign_err <= 1'b1;
      if (act == ACT_FETCH)
        fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage. The memory model returns
// addr ^ 32'hA5A5_0000 for every address.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        imem_ready;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_p;
  logic [31:0] pc_p;
  logic [31:0] pc4_p;
  logic        valid_p;
  logic        misalign_err;
  logic [31:0] fetch_cnt;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  assign imem_instr = imem_addr ^ 32'hA5A5_0000;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .imem_ready   (imem_ready),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .instr_p      (instr_p),
    .pc_p         (pc_p),
    .pc4_p        (pc4_p),
    .valid_p      (valid_p),
    .misalign_err (misalign_err),
    .fetch_cnt    (fetch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_addr"},  imem_addr, 32'h0);
    check({tag, "_instr"}, instr_p, NOP);
    check({tag, "_pc"},    pc_p, 32'h0);
    check({tag, "_pc4"},   pc4_p, 32'h0);
    check({tag, "_valid"}, 32'(valid_p), 32'h0);
    check({tag, "_mis"},   32'(misalign_err), 32'h0);
    check({tag, "_cnt"},   fetch_cnt, 32'h0);
  endtask

  task automatic check_out(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic e_valid, input logic [31:0] e_cnt);
    check({tag, "_pc"},    pc_p, e_pc);
    check({tag, "_instr"}, instr_p, e_instr);
    check({tag, "_valid"}, 32'(valid_p), 32'(e_valid));
    check({tag, "_cnt"},   fetch_cnt, e_cnt);
  endtask

  initial begin
    reset = 1'b0; imem_ready = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #12;
    check_reset_state("rst0");
    @(negedge clk) reset = 1'b1;

    // 1. Three fetches from reset.
    step(); step(); step();
    check_out("t1", 32'h8, 32'hA5A5_0008, 1'b1, 32'd3);
    check("t1_pc4", pc4_p, 32'hC);
    check("t1_addr", imem_addr, 32'hC);
    // Asynchronous reset while clk is high, no edge in between.
    #2 reset = 1'b0;
    #1;
    check_reset_state("rst1");
    @(negedge clk) reset = 1'b1;

    // 2. Stall at pc=0x10 for two edges.
    step(); step(); step(); step();
    check("t2_addr0", imem_addr, 32'h10);
    stall = 1'b1;
    step(); step();
    check_out("t2_hold", 32'hC, 32'hA5A5_000C, 1'b1, 32'd4);
    check("t2_addr", imem_addr, 32'h10);
    stall = 1'b0;
    step();
    check_out("t2_rel", 32'h10, 32'hA5A5_0010, 1'b1, 32'd5);

    // 3. Redirect with simultaneous stall at pc=0x20.
    step(); step(); step();
    check("t3_addr0", imem_addr, 32'h20);
    redirect = 1'b1; redirect_pc = 32'h100; stall = 1'b1;
    step();
    check_out("t3_flush", 32'h1C, NOP, 1'b0, 32'd8);
    check("t3_addr", imem_addr, 32'h100);
    redirect = 1'b0; stall = 1'b0;
    step();
    check_out("t3_tgt", 32'h100, 32'hA5A5_0100, 1'b1, 32'd9);

    // 4. Memory wait states at pc=0x40.
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0; imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t4_bub%0d_valid", i), 32'(valid_p), 32'h0);
      check($sformatf("t4_bub%0d_instr", i), instr_p, NOP);
      check($sformatf("t4_bub%0d_addr", i), imem_addr, 32'h40);
    end
    check("t4_cnt", fetch_cnt, 32'd9);
    imem_ready = 1'b1;
    step();
    check_out("t4_rec", 32'h40, 32'hA5A5_0040, 1'b1, 32'd10);
    step();
    check_out("t4_next", 32'h44, 32'hA5A5_0044, 1'b1, 32'd11);

    // 5a. Misaligned redirect, flag is sticky across later redirects.
    redirect = 1'b1; redirect_pc = 32'h0000_0206;
    step();
    check("t5_addr", imem_addr, 32'h204);
    check("t5_mis", 32'(misalign_err), 32'h1);
    redirect = 1'b0;
    step();
    check_out("t5_fetch", 32'h204, 32'hA5A5_0204, 1'b1, 32'd12);
    redirect = 1'b1; redirect_pc = 32'h300;
    step();
    check("t5_addr2", imem_addr, 32'h300);
    check("t5_mis2", 32'(misalign_err), 32'h1);

    // 5b. PC wrap at the top of the address space.
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    step();
    check_out("t5_top", 32'hFFFF_FFFC, 32'h5A5A_FFFC, 1'b1, 32'd13);
    check("t5_top_pc4", pc4_p, 32'h0);
    step();
    check_out("t5_wrap", 32'h0, 32'hA5A5_0000, 1'b1, 32'd14);
    check("t5_wrap_pc4", pc4_p, 32'h4);
    check("t5_mis3", 32'(misalign_err), 32'h1);

    // Only reset clears the sticky flag.
    #2 reset = 1'b0;
    #1;
    check_reset_state("rst2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
